// File: rtl/axi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axi_pkg
// Description : Shared AXI response codes and the SRAM slave state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package axi_pkg;

  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_REQ  = 3'd1,
    RD_WAIT = 3'd2,
    RD_RSP  = 3'd3,
    WR_DATA = 3'd4,
    WR_RESP = 3'd5
  } state_t;

endpackage
`default_nettype wire

// File: rtl/axi_sram_slave.sv
`default_nettype none
// ============================================================================
// Module      : axi_sram_slave
// Description : AXI3 slave serving one read or write burst at a time from a
//               single-port synchronous 32-bit SRAM.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_sram_slave
  import axi_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int ID_W   = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [ID_W-1:0]   arid,
  input  logic [31:0]       araddr,
  input  logic [3:0]        arlen,
  input  logic              arvalid,
  output logic              arready,
  output logic [ID_W-1:0]   rid,
  output logic [31:0]       rdata,
  output logic [1:0]        rresp,
  output logic              rlast,
  output logic              rvalid,
  input  logic              rready,
  input  logic [ID_W-1:0]   awid,
  input  logic [31:0]       awaddr,
  input  logic [3:0]        awlen,
  input  logic              awvalid,
  output logic              awready,
  input  logic [31:0]       wdata,
  input  logic [3:0]        wstrb,
  input  logic              wvalid,
  output logic              wready,
  output logic [ID_W-1:0]   bid,
  output logic [1:0]        bresp,
  output logic              bvalid,
  input  logic              bready,
  output logic              ram_en,
  output logic [3:0]        ram_wen,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_prio_rd;
  logic [ADDR_W-1:0]   r_addr;
  logic [3:0]          r_len;
  logic [3:0]          r_cnt;
  logic                r_rvalid;
  logic                r_rlast;
  logic                r_bvalid;
  logic [31:0]         r_rdata;
  logic [ID_W-1:0]     r_rid;
  logic [ID_W-1:0]     r_bid;
  logic                w_grant_rd;
  logic                w_grant_wr;
  logic                w_last_beat;
  logic                w_unused;

  // Contention is settled by r_prio_rd; a lone request is always granted.
  assign w_grant_rd  = arvalid & (~awvalid | r_prio_rd);
  assign w_grant_wr  = awvalid & (~arvalid | ~r_prio_rd);
  assign w_last_beat = (r_cnt == r_len);

  assign rid    = r_rid;
  assign rdata  = r_rdata;
  assign rresp  = AXI_RESP_OKAY;
  assign rlast  = r_rlast;
  assign rvalid = r_rvalid;
  assign bid    = r_bid;
  assign bresp  = AXI_RESP_OKAY;
  assign bvalid = r_bvalid;

  assign w_unused = ^{araddr[31:ADDR_W+2], araddr[1:0], awaddr[31:ADDR_W+2], awaddr[1:0]};

  always_comb begin
    w_state_nxt = r_state;
    arready     = 1'b0;
    awready     = 1'b0;
    wready      = 1'b0;
    ram_en      = 1'b0;
    ram_wen     = 4'b0000;
    ram_addr    = r_addr;
    ram_wdata   = 32'h0;
    case (r_state)
      IDLE: begin
        arready = w_grant_rd;
        awready = w_grant_wr;
        if (w_grant_rd)      w_state_nxt = RD_REQ;
        else if (w_grant_wr) w_state_nxt = WR_DATA;
      end
      RD_REQ: begin
        ram_en      = 1'b1;
        w_state_nxt = RD_WAIT;
      end
      RD_WAIT: w_state_nxt = RD_RSP;
      RD_RSP: begin
        if (rready) w_state_nxt = r_rlast ? IDLE : RD_REQ;
      end
      WR_DATA: begin
        wready = 1'b1;
        if (wvalid) begin
          ram_en    = 1'b1;
          ram_wen   = wstrb;
          ram_wdata = wdata;
          if (w_last_beat) w_state_nxt = WR_RESP;
        end
      end
      WR_RESP: begin
        if (bready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state   <= IDLE;
      r_prio_rd <= 1'b1;
      r_addr    <= '0;
      r_len     <= 4'd0;
      r_cnt     <= 4'd0;
      r_rvalid  <= 1'b0;
      r_rlast   <= 1'b0;
      r_bvalid  <= 1'b0;
      r_rdata   <= 32'h0;
      r_rid     <= '0;
      r_bid     <= '0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        IDLE: begin
          if (w_grant_rd) begin
            r_prio_rd <= ~r_prio_rd;
            r_rid     <= arid;
            r_addr    <= araddr[ADDR_W+1:2];
            r_len     <= arlen;
            r_cnt     <= 4'd0;
          end else if (w_grant_wr) begin
            r_prio_rd <= ~r_prio_rd;
            r_bid     <= awid;
            r_addr    <= awaddr[ADDR_W+1:2];
            r_len     <= awlen;
            r_cnt     <= 4'd0;
          end
        end
        RD_WAIT: begin
          r_rdata  <= ram_rdata;
          r_rvalid <= 1'b1;
          r_rlast  <= w_last_beat;
        end
        RD_RSP: begin
          if (rready) begin
            r_rvalid <= 1'b0;
            r_rlast  <= 1'b0;
            r_addr   <= r_addr + 1'b1;
            r_cnt    <= r_cnt + 4'd1;
          end
        end
        WR_DATA: begin
          if (wvalid) begin
            r_addr <= r_addr + 1'b1;
            r_cnt  <= r_cnt + 4'd1;
            if (w_last_beat) r_bvalid <= 1'b1;
          end
        end
        WR_RESP: begin
          if (bready) r_bvalid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_axi_sram_slave.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi_sram_slave
// Description : Scoreboard bench for axi_sram_slave with a behavioural SRAM.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_sram_slave;
  import axi_pkg::*;

  localparam int ADDR_W = 16;
  localparam int ID_W   = 4;
  localparam int DEPTH  = 1 << ADDR_W;
  localparam int TMO    = 200;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  logic [ID_W-1:0]   arid = '0;
  logic [31:0]       araddr = '0;
  logic [3:0]        arlen = '0;
  logic              arvalid = 1'b0;
  logic              arready;
  logic [ID_W-1:0]   rid;
  logic [31:0]       rdata;
  logic [1:0]        rresp;
  logic              rlast;
  logic              rvalid;
  logic              rready = 1'b0;
  logic [ID_W-1:0]   awid = '0;
  logic [31:0]       awaddr = '0;
  logic [3:0]        awlen = '0;
  logic              awvalid = 1'b0;
  logic              awready;
  logic [31:0]       wdata = '0;
  logic [3:0]        wstrb = '0;
  logic              wvalid = 1'b0;
  logic              wready;
  logic [ID_W-1:0]   bid;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready = 1'b0;
  logic              ram_en;
  logic [3:0]        ram_wen;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_rdata = '0;

  axi_sram_slave #(.ADDR_W(ADDR_W), .ID_W(ID_W)) dut (
    .clk(clk), .resetn(resetn),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .ram_en(ram_en), .ram_wen(ram_wen), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  // Behavioural SRAM; preload port shares the single write process.
  logic [31:0]       mem    [DEPTH];
  logic [31:0]       shadow [DEPTH];
  logic              pl_en = 1'b0;
  logic [ADDR_W-1:0] pl_addr = '0;
  logic [31:0]       pl_data = '0;

  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (ram_en) begin
      if (ram_wen == 4'b0000) ram_rdata <= mem[ram_addr];
      else for (int k = 0; k < 4; k++)
        if (ram_wen[k]) mem[ram_addr][8*k +: 8] <= ram_wdata[8*k +: 8];
    end
  end

  typedef struct packed {
    logic [31:0]     data;
    logic [ID_W-1:0] id;
    logic            last;
  } rbeat_t;

  rbeat_t          rd_q[$];
  logic [ID_W-1:0] b_q[$];
  int              grant_log[$];
  logic            m_prio_rd = 1'b1;
  int              n_vec = 0;
  int              n_err = 0;

  task automatic preload(input logic [ADDR_W-1:0] a, input logic [31:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d; shadow[a] = d;
    @(posedge clk); #1 pl_en = 1'b0;
  endtask

  task automatic send_ar(input logic [ID_W-1:0] id, input logic [31:0] addr, input logic [3:0] len);
    int t;
    rbeat_t e;
    logic [ADDR_W-1:0] w;
    t = 0;
    arid = id; araddr = addr; arlen = len; arvalid = 1'b1;
    @(negedge clk);
    while (!arready && t < TMO) begin @(negedge clk); t++; end
    n_vec++;
    if (!arready) begin
      n_err++;
      $display("FAIL ar_handshake: arready=%b, required 1 within %0d cycles", arready, TMO);
    end else begin
      grant_log.push_back(0);
      m_prio_rd = ~m_prio_rd;
      w = addr[ADDR_W+1:2];
      for (int b = 0; b <= int'(len); b++) begin
        e.data = shadow[w]; e.id = id; e.last = (b == int'(len));
        rd_q.push_back(e);
        w++;
      end
    end
    @(posedge clk); #1 arvalid = 1'b0;
  endtask

  task automatic send_aw_w(input logic [ID_W-1:0] id, input logic [31:0] addr, input logic [3:0] len,
                           input logic [31:0] d0, input logic [3:0] strb);
    int t;
    logic [ADDR_W-1:0] w;
    logic [31:0] d;
    t = 0;
    awid = id; awaddr = addr; awlen = len; awvalid = 1'b1;
    @(negedge clk);
    while (!awready && t < TMO) begin @(negedge clk); t++; end
    n_vec++;
    if (!awready) begin
      n_err++;
      $display("FAIL aw_handshake: awready=%b, required 1 within %0d cycles", awready, TMO);
      @(posedge clk); #1 awvalid = 1'b0;
      return;
    end
    grant_log.push_back(1);
    m_prio_rd = ~m_prio_rd;
    b_q.push_back(id);
    @(posedge clk); #1 awvalid = 1'b0;
    w = addr[ADDR_W+1:2];
    for (int b = 0; b <= int'(len); b++) begin
      d = d0 + 32'(b) * 32'h01010101;
      wdata = d; wstrb = strb; wvalid = 1'b1;
      t = 0;
      @(negedge clk);
      while (!wready && t < TMO) begin @(negedge clk); t++; end
      n_vec++;
      if (!wready || ram_en !== 1'b1 || ram_wen !== strb || ram_addr !== w || ram_wdata !== d) begin
        n_err++;
        $display("FAIL w_beat%0d: wready=%b en=%b wen=%b addr=%h wdata=%h, required 1 1 %b %h %h",
                 b, wready, ram_en, ram_wen, ram_addr, ram_wdata, strb, w, d);
      end
      for (int k = 0; k < 4; k++) if (strb[k]) shadow[w][8*k +: 8] = d[8*k +: 8];
      @(posedge clk); #1;
      w++;
    end
    wvalid = 1'b0;
  endtask

  task automatic recv_r(input int nb, input int stall_beat, input int stall_cyc);
    rbeat_t e;
    logic [31:0] held;
    int t;
    for (int b = 0; b < nb; b++) begin
      t = 0;
      rready = (b != stall_beat);
      @(negedge clk);
      while (!rvalid && t < TMO) begin @(negedge clk); t++; end
      if (!rvalid) begin
        n_vec++; n_err++;
        $display("FAIL r_timeout beat%0d: rvalid=%b, required 1", b, rvalid);
        rready = 1'b0;
        return;
      end
      if (b == stall_beat) begin
        held = rdata;
        for (int s = 0; s < stall_cyc; s++) begin
          @(negedge clk);
          n_vec++;
          if (rvalid !== 1'b1 || rdata !== held) begin
            n_err++;
            $display("FAIL r_stall%0d: rvalid=%b rdata=%h, required 1 %h", s, rvalid, rdata, held);
          end
        end
        @(posedge clk); #1 rready = 1'b1;
        @(negedge clk);
      end
      n_vec++;
      if (rd_q.size() == 0) begin
        n_err++;
        $display("FAIL r_unexpected: rdata=%h, required no beat", rdata);
      end else begin
        e = rd_q.pop_front();
        if (rdata !== e.data || rid !== e.id || rlast !== e.last || rresp !== AXI_RESP_OKAY) begin
          n_err++;
          $display("FAIL r_beat%0d: data=%h id=%h last=%b resp=%b, required %h %h %b 00",
                   b, rdata, rid, rlast, rresp, e.data, e.id, e.last);
        end
      end
      @(posedge clk); #1;
    end
    rready = 1'b0;
  endtask

  task automatic recv_b();
    logic [ID_W-1:0] e;
    int t;
    t = 0;
    bready = 1'b1;
    @(negedge clk);
    while (!bvalid && t < TMO) begin @(negedge clk); t++; end
    n_vec++;
    if (!bvalid || b_q.size() == 0) begin
      n_err++;
      $display("FAIL b_resp: bvalid=%b pending=%0d, required 1 and >0", bvalid, b_q.size());
    end else begin
      e = b_q.pop_front();
      if (bid !== e || bresp !== AXI_RESP_OKAY) begin
        n_err++;
        $display("FAIL b_resp: bid=%h bresp=%b, required %h 00", bid, bresp, e);
      end
    end
    @(posedge clk); #1 bready = 1'b0;
  endtask

  task automatic apply_reset();
    resetn = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    n_vec++;
    if ({arready, awready, wready, rvalid, bvalid, rlast, ram_en, ram_wen} !== 11'b0) begin
      n_err++;
      $display("FAIL reset_ctrl: ar/aw/w/rv/bv/rl/en/wen=%b, required 0", 
               {arready, awready, wready, rvalid, bvalid, rlast, ram_en, ram_wen});
    end
    m_prio_rd = 1'b1;
    rd_q.delete(); b_q.delete();
    @(posedge clk); #1 resetn = 1'b1;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    n_vec++;
    if (rdata !== 32'h0 || rid !== '0 || bid !== '0) begin
      n_err++;
      $display("FAIL reset_data: rdata=%h rid=%h bid=%h, required 0 0 0", rdata, rid, bid);
    end
    apply_reset();
  endtask

  task automatic test_single_read();
    int lat;
    preload(16'h0040, 32'hDEADBEEF);
    send_ar(4'h0, 32'h100, 4'd0);
    lat = 0;
    do begin @(negedge clk); lat++; end while (!rvalid && lat < TMO);
    n_vec++;
    if (lat !== 3) begin
      n_err++;
      $display("FAIL read_latency: %0d cycles, required 3", lat);
    end
    @(posedge clk); #1;
    recv_r(1, -1, 0);
  endtask

  task automatic test_byte_write();
    send_aw_w(4'h5, 32'h102, 4'd0, 32'h00AB0000, 4'b0100);
    recv_b();
    n_vec++;
    if (mem[16'h0040] !== 32'hDEABBEEF) begin
      n_err++;
      $display("FAIL byte_write: mem=%h, required deabbeef", mem[16'h0040]);
    end
    send_ar(4'h9, 32'h100, 4'd0);
    recv_r(1, -1, 0);
  endtask

  task automatic contend_round(input logic [31:0] ra, input logic [31:0] wa);
    int exp_first;
    exp_first = m_prio_rd ? 0 : 1;
    grant_log.delete();
    fork
      send_ar(4'h1, ra, 4'd0);
      send_aw_w(4'h2, wa, 4'd0, $urandom, 4'hF);
      recv_r(1, -1, 0);
      recv_b();
    join
    n_vec++;
    if (grant_log.size() != 2 || grant_log[0] != exp_first || grant_log[1] != 1 - exp_first) begin
      n_err++;
      $display("FAIL grant_order: n=%0d first=%0d, required 2 %0d", grant_log.size(),
               (grant_log.size() > 0) ? grant_log[0] : -1, exp_first);
    end
  endtask

  task automatic test_contention();
    preload(16'h0100, 32'h11112222);
    contend_round(32'h400, 32'h800);
    send_ar(4'h3, 32'h400, 4'd0);
    recv_r(1, -1, 0);
    contend_round(32'h400, 32'h804);
  endtask

  task automatic test_burst_read();
    for (int i = 0; i < 4; i++) preload(ADDR_W'(16'h0080 + i), $urandom);
    send_ar(4'h3, 32'h200, 4'd3);
    recv_r(4, 1, 5);
  endtask

  task automatic test_wrap();
    preload(16'hFFFF, 32'hCAFEF00D);
    preload(16'h0000, 32'h0BADC0DE);
    send_ar(4'h4, 32'h0003FFFC, 4'd1);
    recv_r(2, -1, 0);
    send_aw_w(4'hA, 32'hF003FFF8, 4'd3, 32'h10203040, 4'hF);
    recv_b();
    send_ar(4'hB, 32'h0003FFF8, 4'd3);
    recv_r(4, -1, 0);
  endtask

  task automatic test_w_before_aw();
    wvalid = 1'b1; wdata = 32'h55AA55AA; wstrb = 4'hF;
    repeat (3) @(negedge clk);
    n_vec++;
    if (wready !== 1'b0 || ram_en !== 1'b0) begin
      n_err++;
      $display("FAIL w_early: wready=%b ram_en=%b, required 0 0", wready, ram_en);
    end
    @(posedge clk); #1;
    send_aw_w(4'hC, 32'h300, 4'd1, 32'hA5A5A5A5, 4'b1001);
    recv_b();
    send_ar(4'hD, 32'h300, 4'd1);
    recv_r(2, -1, 0);
  endtask

  task automatic test_reset_mid();
    int t;
    send_ar(4'h6, 32'h100, 4'd0);
    t = 0;
    @(negedge clk);
    while (!rvalid && t < TMO) begin @(negedge clk); t++; end
    @(posedge clk); #1;
    apply_reset();
    send_ar(4'h7, 32'h100, 4'd0);
    recv_r(1, -1, 0);
    send_aw_w(4'h8, 32'h104, 4'd0, 32'h12345678, 4'hF);
    t = 0;
    @(negedge clk);
    while (!bvalid && t < TMO) begin @(negedge clk); t++; end
    @(posedge clk); #1;
    apply_reset();
    send_aw_w(4'hE, 32'h108, 4'd0, 32'h87654321, 4'hF);
    recv_b();
    send_ar(4'hF, 32'h104, 4'd1);
    recv_r(2, -1, 0);
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_byte_write();
    test_contention();
    test_burst_read();
    test_wrap();
    test_w_before_aw();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
`default_nettype wire
